gate_truth_table_engine: RTL and testbench

Parametrised, self-sequencing truth-table generator for an N-input logic gate of selectable type. On a start pulse it sweeps all 2^N input combinations, one row per accepted handshake. Each row (inputs and gate output) is streamed over a valid/ready port. The block accumulates the full truth table and a count of true rows, then pulses done. It is the hardware successor to the two-input gate benches: it serves as the stimulus/characterisation engine in the logic-lab top level.

---
 rtl/gate_truth_table_engine.sv | 72 +++++++
 tb/tb_gate_truth_table_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_engine.sv
// gate_truth_table_engine: sweeps all 2^N inputs of a selectable gate, streaming rows and accumulating the truth table
module gate_truth_table_engine #(
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic                row_ready,
  output logic                row_valid,
  output logic [N-1:0]        row_in,
  output logic                row_y,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   truth_table,
  output logic [N:0]          ones_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] idx;
  logic [2:0] mode_q;
  logic y, fire, last;
  always_comb begin
    y = 1'b0;
    case (mode_q)
      3'd0: y = &idx;
      3'd1: y = |idx;
      3'd2: y = ~&idx;
      3'd3: y = ~|idx;
      3'd4: y = ^idx;
      3'd5: y = ~^idx;
      3'd6: y = idx[0];
      default: y = ~idx[0];
    endcase
  end
  assign fire = (state == RUN) && row_ready;
  assign last = (idx == {N{1'b1}});
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN:  state_nx = (fire && last) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // The terminal row is checked before incrementing, so idx never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      mode_q <= 3'd0;
      truth_table <= '0;
      ones_count <= '0;
    end else if (state == IDLE && start) begin
      idx <= '0;
      mode_q <= mode;
      truth_table <= '0;
      ones_count <= '0;
    end else if (fire) begin
      truth_table[idx] <= y;
      ones_count <= ones_count + {{N{1'b0}}, y};
      if (!last) idx <= idx + 1'b1;
    end
  end
  assign row_valid = (state == RUN);
  assign row_in = row_valid ? idx : '0;
  assign row_y = row_valid & y;
  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_gate_truth_table_engine.sv
// tb_gate_truth_table_engine: vector table plus random sweeps for N=2 and N=3 instances against a behavioural model
module tb_gate_truth_table_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0, start3 = 1'b0, ready2 = 1'b0, ready3 = 1'b0;
  logic [2:0] mode2 = 3'd0, mode3 = 3'd0;
  logic v2, v3, y2, y3, b2, b3, d2, d3;
  logic [1:0] rin2;
  logic [2:0] rin3;
  logic [3:0] tt2;
  logic [7:0] tt3;
  logic [2:0] oc2;
  logic [3:0] oc3;
  logic sel3 = 1'b0;
  logic v, y, b, d;
  logic [7:0] rin, tt;
  logic [3:0] oc;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  gate_truth_table_engine #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .row_ready(ready2),
    .row_valid(v2), .row_in(rin2), .row_y(y2), .busy(b2), .done(d2),
    .truth_table(tt2), .ones_count(oc2));
  gate_truth_table_engine #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .row_ready(ready3),
    .row_valid(v3), .row_in(rin3), .row_y(y3), .busy(b3), .done(d3),
    .truth_table(tt3), .ones_count(oc3));

  always_comb begin
    v = sel3 ? v3 : v2;
    y = sel3 ? y3 : y2;
    b = sel3 ? b3 : b2;
    d = sel3 ? d3 : d2;
    rin = sel3 ? {5'd0, rin3} : {6'd0, rin2};
    tt = sel3 ? tt3 : {4'd0, tt2};
    oc = sel3 ? oc3 : {1'b0, oc2};
  end

  typedef struct {
    int n;
    logic [2:0] m;
    int rpat;
    bit poke;
    logic [7:0] tt;
    int ones;
    int dc;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Gate output computed from the definition of each gate on the integer k.
  function automatic bit ref_y(input int m, input int k, input int n);
    int ones = 0;
    bit all1 = (k == (1 << n) - 1);
    for (int i = 0; i < n; i++) ones += (k >> i) & 1;
    case (m)
      0: return all1;
      1: return k != 0;
      2: return !all1;
      3: return k == 0;
      4: return ones % 2 == 1;
      5: return ones % 2 == 0;
      6: return k % 2 == 1;
      default: return k % 2 == 0;
    endcase
  endfunction

  task automatic drive(input int n, input logic s, input logic [2:0] m, input logic r);
    if (n == 3) begin start3 = s; mode3 = m; ready3 = r; end
    else begin start2 = s; mode2 = m; ready2 = r; end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, v, 0);
    chk({tag, "_row_in"}, rin, 0);
    chk({tag, "_row_y"}, y, 0);
    chk({tag, "_busy"}, b, 0);
    chk({tag, "_done"}, d, 0);
    chk({tag, "_tt"}, tt, 0);
    chk({tag, "_ones"}, oc, 0);
  endtask

  task automatic sweep(input int n, input logic [2:0] m, input int rpat, input bit poke,
                       input logic [7:0] etT, input int eones, input int edc, input bit use_exp);
    int idx = 0, ones_m = 0, done_c = 0, last = (1 << n) - 1;
    logic [7:0] tt_m = 8'd0;
    bit in_run = 1'b1, finished = 1'b0, r;
    logic [2:0] cur_mode = m;
    sel3 = (n == 3);
    @(negedge clk);
    drive(n, 1'b1, m, 1'b1);
    @(posedge clk);
    #1 drive(n, 1'b0, m, 1'b1);
    for (int c = 1; c <= 300 && !finished; c++) begin
      @(negedge clk);
      if (in_run) begin
        chk("run_valid", v, 1);
        chk("run_row_in", rin, idx);
        chk("run_row_y", y, ref_y(m, idx, n));
        chk("run_busy", b, 1);
        chk("run_done", d, 0);
        r = (rpat == 0) ? 1'b1 : (rpat == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
        if (poke && c == 3) cur_mode = 3'd0;
        drive(n, poke && c == 3, cur_mode, r);
        if (r) begin
          tt_m[idx] = ref_y(m, idx, n);
          ones_m += ref_y(m, idx, n);
          if (idx == last) in_run = 1'b0;
          else idx++;
        end
      end else begin
        chk("done_valid", v, 0);
        chk("done_busy", b, 1);
        chk("done_pulse", d, 1);
        done_c = c;
        finished = 1'b1;
        drive(n, 1'b0, cur_mode, 1'b1);
      end
    end
    if (!finished) begin
      tests++; fails++;
      $display("FAIL sweep_timeout: no done within 300 cycles (n=%0d mode=%0d)", n, m);
    end
    @(negedge clk);
    chk("after_busy", b, 0);
    chk("after_done", d, 0);
    chk("model_tt", tt, tt_m);
    chk("model_ones", oc, ones_m);
    if (use_exp) begin
      chk("exp_tt", tt, etT);
      chk("exp_ones", oc, eones);
      chk("exp_done_cycle", done_c, edc);
    end
    @(negedge clk);
    chk("hold_tt", tt, tt_m);
  endtask

  initial begin
    vecs[0] = '{2, 3'd3, 0, 1'b0, 8'h01, 1, 5};
    vecs[1] = '{2, 3'd4, 1, 1'b0, 8'h06, 2, 9};
    vecs[2] = '{3, 3'd0, 0, 1'b0, 8'h80, 1, 9};
    vecs[3] = '{3, 3'd2, 0, 1'b0, 8'h7F, 7, 9};
    vecs[4] = '{2, 3'd7, 0, 1'b1, 8'h05, 2, 5};
    vecs[5] = '{2, 3'd6, 0, 1'b0, 8'h0A, 2, 5};
    vecs[6] = '{3, 3'd5, 0, 1'b0, 8'h69, 4, 9};
    vecs[7] = '{2, 3'd1, 1, 1'b0, 8'h0E, 3, 9};
    repeat (3) @(negedge clk);
    sel3 = 1'b0; #1 check_zero("rst2");
    sel3 = 1'b1; #1 check_zero("rst3");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      sweep(vecs[i].n, vecs[i].m, vecs[i].rpat, vecs[i].poke, vecs[i].tt, vecs[i].ones, vecs[i].dc, 1'b1);
    // Reset in the middle of an OR sweep, when row 4 is presented.
    sel3 = 1'b1;
    @(negedge clk);
    drive(3, 1'b1, 3'd1, 1'b1);
    @(posedge clk);
    #1 drive(3, 1'b0, 3'd1, 1'b1);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (v && rin == 8'd4) seen = 1'b1;
      end
      chk("reach_row4", seen, 1);
      chk("partial_tt", tt, 8'h0E);
    end
    rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    check_zero("midrst_hold");
    rst_n = 1'b1;
    sweep(3, 3'd1, 0, 1'b0, 8'hFE, 7, 9, 1'b1);
    for (int i = 0; i < 12; i++)
      sweep($urandom_range(0, 1) ? 3 : 2, 3'($urandom_range(0, 7)), 2, 1'($urandom_range(0, 1)),
            8'd0, 0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
